huffman_stream_encoder: RTL

- Transmit-side counterpart of the Huffman code-group detector: maps fixed-width data symbols to variable-length Huffman codes and packs them MSB-first into fixed-width output words.
- Sits between the CNN weight/activation compressor front-end and the packed-stream writer.
- Code table is loaded at runtime through the same d/h/w configuration triplet the decoder side uses, so both ends are programmed from one table.

---
 rtl/huffman_pkg.sv | 34 +++
 rtl/huffman_code_table.sv | 50 +++++
 rtl/huffman_stream_encoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared widths, FSM state type and code-table entry type for
// the Huffman stream encoder.
//   NUM_OF_CHARS : table entries (2**D_W)
//   D_W          : symbol width
//   C_W          : maximum code width
//   W_W          : width-field bits (holds 0..C_W)
//   OUT_W        : packed output word width (>= C_W)
//   OB_W         : width of the o_bits count
//   ACC_W        : accumulator width (one word plus one maximal code)
//   FILL_W       : width of the accumulator fill count (0..ACC_W)
package huffman_pkg;

  localparam int NUM_OF_CHARS = 16;
  localparam int D_W          = 4;
  localparam int C_W          = 4;
  localparam int W_W          = 3;
  localparam int OUT_W        = 8;
  localparam int OB_W         = $clog2(OUT_W) + 1;
  localparam int ACC_W        = OUT_W + C_W;
  localparam int FILL_W       = $clog2(ACC_W + 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Code is right-aligned; only width[] low bits of code are meaningful.
  typedef struct packed {
    logic [C_W-1:0] code;
    logic [W_W-1:0] width;
    logic           active;
  } entry_t;

endpackage

// File: rtl/huffman_code_table.sv
// huffman_code_table: symbol -> {code, width, active} register file.
// Mirror of the decoder-side detector table.
//   clk, rst   : clock, synchronous active-high reset (all entries inactive)
//   clear      : deactivate every entry (wins over wr_en)
//   wr_en      : write entry[wr_idx] = {wr_code, wr_width} and mark active
//   rd_idx     : combinational read index
//   rd_entry   : entry at rd_idx
module huffman_code_table
  import huffman_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           wr_en,
  input  logic [D_W-1:0] wr_idx,
  input  logic [C_W-1:0] wr_code,
  input  logic [W_W-1:0] wr_width,
  input  logic [D_W-1:0] rd_idx,
  output entry_t         rd_entry
);

  entry_t tbl_q [NUM_OF_CHARS];
  entry_t tbl_d [NUM_OF_CHARS];

  always_comb begin
    tbl_d = tbl_q;
    if (clear) begin
      for (int i = 0; i < NUM_OF_CHARS; i++) begin
        tbl_d[i].active = 1'b0;
      end
    end else if (wr_en) begin
      tbl_d[wr_idx].code   = wr_code;
      tbl_d[wr_idx].width  = wr_width;
      tbl_d[wr_idx].active = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OF_CHARS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_entry = tbl_q[rd_idx];

endmodule

// File: rtl/huffman_stream_encoder.sv
// huffman_stream_encoder: maps symbols to runtime-programmed Huffman codes and
// packs them MSB-first into OUT_W-bit words.
// Optional build macro: HUFF_ENC_STATS_EN adds sym_cnt / bit_cnt counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   new_conf                 : clear all table entries (priority over en_conf)
//   en_conf, d_conf,
//   h_conf, w_conf           : write one table entry (ignored when busy or
//                              w_conf outside 1..C_W)
//   s_valid/s_ready/s_data   : input symbol stream
//   flush                    : end-of-stream request pulse
//   o_valid/o_ready/o_data   : packed word stream, first bit at MSB
//   o_bits                   : valid bits in o_data (OUT_W except last flush word)
//   unmapped_err             : pulse, accepted symbol had no active entry
//   flush_done               : pulse, flush finished and stream empty
//   busy                     : data in flight or flushing
//   sym_cnt, bit_cnt         : (HUFF_ENC_STATS_EN) accepted symbols / code bits
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds valid and payload stable until that edge.
module huffman_stream_encoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             new_conf,
  input  logic             en_conf,
  input  logic [D_W-1:0]   d_conf,
  input  logic [C_W-1:0]   h_conf,
  input  logic [W_W-1:0]   w_conf,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [D_W-1:0]   s_data,
  input  logic             flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic [OB_W-1:0]  o_bits,
  output logic             unmapped_err,
  output logic             flush_done,
`ifdef HUFF_ENC_STATS_EN
  output logic [31:0]      sym_cnt,
  output logic [31:0]      bit_cnt,
`endif
  output logic             busy
);

  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              o_valid_q, o_valid_d;
  logic [OUT_W-1:0]  o_data_q, o_data_d;
  logic [OB_W-1:0]   o_bits_q, o_bits_d;
  logic              unmapped_err_q, unmapped_err_d;
  logic              flush_done_q, flush_done_d;

  entry_t            entry;
  logic              wr_ok;
  logic              accept;
  logic              out_free;
  logic              emit_full;
  logic              emit_part;
  logic [ACC_W-1:0]  base_acc;
  logic [FILL_W-1:0] base_fill;
  logic [C_W-1:0]    code_m;
  logic [C_W-1:0]    code_l;
  logic [ACC_W-1:0]  app;
  logic              append;

  assign busy    = (fill_q != '0) || o_valid_q || (state_q == FLUSH);
  assign s_ready = (state_q == RUN) && (fill_q < OUT_W_F);
  assign accept  = s_valid && s_ready;

  // Table writes are locked out while data is in flight so codes cannot
  // change under a partially packed word.
  assign wr_ok = en_conf && !new_conf && (w_conf != '0) &&
                 (w_conf <= W_W'(C_W)) && !busy;

  huffman_code_table u_table (
    .clk      (clk),
    .rst      (rst),
    .clear    (new_conf),
    .wr_en    (wr_ok),
    .wr_idx   (d_conf),
    .wr_code  (h_conf),
    .wr_width (w_conf),
    .rd_idx   (s_data),
    .rd_entry (entry)
  );

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    fill_d         = fill_q;
    o_valid_d      = o_valid_q;
    o_data_d       = o_data_q;
    o_bits_d       = o_bits_q;
    unmapped_err_d = 1'b0;
    flush_done_d   = 1'b0;

    out_free  = !o_valid_q || o_ready;
    emit_full = (fill_q >= OUT_W_F) && out_free;
    emit_part = (state_q == FLUSH) && (fill_q != '0) &&
                (fill_q < OUT_W_F) && out_free;

    if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end

    base_acc  = acc_q;
    base_fill = fill_q;
    // Bits past fill are always zero, so a partial word is already padded.
    if (emit_full) begin
      o_data_d  = acc_q[ACC_W-1 -: OUT_W];
      o_bits_d  = OB_W'(OUT_W);
      o_valid_d = 1'b1;
      base_acc  = acc_q << OUT_W;
      base_fill = fill_q - OUT_W_F;
    end else if (emit_part) begin
      o_data_d  = acc_q[ACC_W-1 -: OUT_W];
      o_bits_d  = OB_W'(fill_q);
      o_valid_d = 1'b1;
      base_acc  = '0;
      base_fill = '0;
    end

    // Mask the code to its width, left-justify it, then drop it in right
    // after the existing fill bits.
    append = accept && entry.active;
    code_m = entry.code & ~({C_W{1'b1}} << entry.width);
    code_l = code_m << (W_W'(C_W) - entry.width);
    app    = {code_l, {(ACC_W - C_W){1'b0}}} >> base_fill;

    if (append) begin
      acc_d  = base_acc | app;
      fill_d = base_fill + FILL_W'(entry.width);
    end else begin
      acc_d  = base_acc;
      fill_d = base_fill;
    end

    if (accept && !entry.active) begin
      unmapped_err_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((fill_q == '0) && !o_valid_q) begin
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      acc_q          <= '0;
      fill_q         <= '0;
      o_valid_q      <= 1'b0;
      o_data_q       <= '0;
      o_bits_q       <= '0;
      unmapped_err_q <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      fill_q         <= fill_d;
      o_valid_q      <= o_valid_d;
      o_data_q       <= o_data_d;
      o_bits_q       <= o_bits_d;
      unmapped_err_q <= unmapped_err_d;
      flush_done_q   <= flush_done_d;
    end
  end

  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_bits       = o_bits_q;
  assign unmapped_err = unmapped_err_q;
  assign flush_done   = flush_done_q;

`ifdef HUFF_ENC_STATS_EN
  logic [31:0] sym_cnt_q, sym_cnt_d;
  logic [31:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (new_conf) begin
      sym_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      if (accept) sym_cnt_d = sym_cnt_q + 32'd1;
      if (append) bit_cnt_d = bit_cnt_q + 32'(entry.width);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sym_cnt = sym_cnt_q;
  assign bit_cnt = bit_cnt_q;
`endif

endmodule
